// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Optional checksum stage is selected with BOOT_CHECKSUM_EN.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    RUN  = 3'd5
  } BootState;

  localparam logic [7:0] BOOT_SYNC = 8'hA5;

  // Running image checksum is a plain byte-wise XOR.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/uart_boot_loader_uart_rx.sv
// 8N1 UART receiver with 2-FF input synchronizer, start-bit glitch rejection
// and stop-bit framing check. Part of uart_boot_loader (macro BOOT_CHECKSUM_EN unused here).
module uart_rx
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t        state_r;
  rx_state_t        state_s;
  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             fall_s;
  logic             half_tick_s;
  logic             full_tick_s;

  assign fall_s      = rx_prev_r & ~rx_sync_r;
  assign half_tick_s = (cnt_r == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign full_tick_s = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));

  // Input synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= RX_IDLE;
    else     state_r <= state_s;
  end

  // Receiver next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RX_IDLE:  if (fall_s) state_s = RX_START; else state_s = RX_IDLE;
      // A start bit that is high again at mid-bit was only a glitch.
      RX_START: if (half_tick_s) state_s = rx_sync_r ? RX_IDLE : RX_DATA; else state_s = RX_START;
      RX_DATA:  if (full_tick_s && bit_idx_r == 3'd7) state_s = RX_STOP; else state_s = RX_DATA;
      RX_STOP:  if (full_tick_s) state_s = RX_IDLE; else state_s = RX_STOP;
      default:  state_s = RX_IDLE;
    endcase
  end

  // Bit timing, data shifting and registered byte outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CNT_W{1'b0}};
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      o_byte      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (state_r == RX_IDLE || state_s != state_r || full_tick_s) cnt_r <= {CNT_W{1'b0}};
      else cnt_r <= cnt_r + CNT_W'(1);
      if (state_r == RX_DATA && full_tick_s) begin
        shift_r   <= {rx_sync_r, shift_r[7:1]};
        bit_idx_r <= bit_idx_r + 3'd1;
      end else if (state_r != RX_DATA) begin
        bit_idx_r <= 3'd0;
      end
      if (state_r == RX_STOP && full_tick_s) begin
        o_valid     <= rx_sync_r;
        o_frame_err <= ~rx_sync_r;
        if (rx_sync_r) o_byte <= shift_r;
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial image loader: frames A5/LEN/data over UART into memory and releases CPU reset.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte before RUN.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12,
  parameter int BASE_ADDR    = 0,
  parameter int MAX_WORDS    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx,
  output logic              o_cpu_rst,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [31:0]       o_wdata,
  output logic              o_busy,
  output logic              o_error
);

`ifdef BOOT_CHECKSUM_EN
  localparam BootState LOAD_DONE = CSUM;
`else
  localparam BootState LOAD_DONE = RUN;
`endif

  logic [7:0]        rx_byte_s;
  logic              rx_valid_s;
  logic              rx_ferr_s;
  BootState          state_r;
  BootState          state_s;
  logic [7:0]        len_lo_r;
  logic [15:0]       word_cnt_r;
  logic [15:0]       word_idx_r;
  logic [1:0]        byte_idx_r;
  logic [23:0]       shift_r;
  logic [15:0]       len_s;
  logic              len_big_s;
  logic              last_word_s;
  logic              word_done_s;
  logic              sync_seen_s;
  logic              csum_bad_s;
  logic              cpu_rst_s;
  logic              busy_s;
  logic              error_s;
  logic [ADDR_W-1:0] base_addr_s;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (i_rx),
    .o_byte      (rx_byte_s),
    .o_valid     (rx_valid_s),
    .o_frame_err (rx_ferr_s)
  );

  assign base_addr_s = ADDR_W'(BASE_ADDR);
  assign len_s       = {rx_byte_s, len_lo_r};
  assign len_big_s   = ({1'b0, len_s} > 17'(MAX_WORDS));
  assign last_word_s = (word_idx_r == word_cnt_r - 16'd1);
  assign word_done_s = rx_valid_s && (byte_idx_r == 2'd3);
  assign sync_seen_s = rx_valid_s && (rx_byte_s == BOOT_SYNC);

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_r;

  assign csum_bad_s = (state_r == CSUM) && rx_valid_s && (rx_byte_s != csum_r);

  // Checksum accumulates from LEN_LO onward; LEN0 restarts it for every frame.
  always_ff @(posedge clk) begin
    if (rst) csum_r <= 8'h00;
    else if (rx_valid_s && state_r == LEN0) csum_r <= rx_byte_s;
    else if (rx_valid_s && (state_r == LEN1 || state_r == DATA)) csum_r <= csum_fold(csum_r, rx_byte_s);
    else csum_r <= csum_r;
  end
`else
  assign csum_bad_s = 1'b0;
`endif

  // Loader state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Loader next-state logic; any framing error during a load aborts to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: if (sync_seen_s) state_s = LEN0; else state_s = IDLE;
      LEN0: if (rx_ferr_s) state_s = IDLE; else if (rx_valid_s) state_s = LEN1; else state_s = LEN0;
      LEN1: begin
        if (rx_ferr_s) state_s = IDLE;
        else if (rx_valid_s) begin
          if (len_big_s) state_s = IDLE;
          else if (len_s == 16'd0) state_s = LOAD_DONE;
          else state_s = DATA;
        end else state_s = LEN1;
      end
      DATA: if (rx_ferr_s) state_s = IDLE;
            else if (word_done_s && last_word_s) state_s = LOAD_DONE;
            else state_s = DATA;
`ifdef BOOT_CHECKSUM_EN
      CSUM: if (rx_ferr_s) state_s = IDLE;
            else if (rx_valid_s) state_s = csum_bad_s ? IDLE : RUN;
            else state_s = CSUM;
`endif
      RUN:  if (sync_seen_s) state_s = LEN0; else state_s = RUN;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the status outputs, derived from the upcoming state.
  always_comb begin
    cpu_rst_s = (state_s != RUN);
    busy_s    = (state_s != IDLE) && (state_s != RUN);
    error_s   = o_error;
    if (rx_ferr_s) error_s = 1'b1;
    else if (sync_seen_s && (state_r == IDLE || state_r == RUN)) error_s = 1'b0;
    else if (state_r == LEN1 && rx_valid_s && len_big_s) error_s = 1'b1;
    else if (csum_bad_s) error_s = 1'b1;
    else error_s = o_error;
  end

  // Registered status outputs so o_cpu_rst only ever changes on a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_cpu_rst <= 1'b1;
      o_busy    <= 1'b0;
      o_error   <= 1'b0;
    end else begin
      o_cpu_rst <= cpu_rst_s;
      o_busy    <= busy_s;
      o_error   <= error_s;
    end
  end

  // Header capture, little-endian word assembly and memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_r   <= 8'h00;
      word_cnt_r <= 16'd0;
      word_idx_r <= 16'd0;
      byte_idx_r <= 2'd0;
      shift_r    <= 24'h000000;
      o_wen      <= 1'b0;
      o_waddr    <= base_addr_s;
      o_wdata    <= 32'h00000000;
    end else begin
      o_wen <= 1'b0;
      if (state_r == LEN0 && rx_valid_s) len_lo_r <= rx_byte_s;
      if (state_r == LEN1 && rx_valid_s) begin
        word_cnt_r <= len_s;
        word_idx_r <= 16'd0;
        byte_idx_r <= 2'd0;
      end
      if (state_r == DATA && rx_valid_s) begin
        shift_r    <= {rx_byte_s, shift_r[23:8]};
        byte_idx_r <= byte_idx_r + 2'd1;
        if (byte_idx_r == 2'd3) begin
          o_wen      <= 1'b1;
          o_waddr    <= base_addr_s + ADDR_W'(word_idx_r);
          o_wdata    <= {rx_byte_s, shift_r};
          word_idx_r <= word_idx_r + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed self-checking bench for uart_boot_loader (works with or without BOOT_CHECKSUM_EN).
module tb_uart_boot_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rx = 1'b1;
  logic        o_cpu_rst, o_wen, o_busy, o_error;
  logic [11:0] o_waddr;
  logic [31:0] o_wdata;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  tb_csum;
  logic [43:0] wq[$];
  logic [43:0] got_w;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(12), .BASE_ADDR(0), .MAX_WORDS(4096)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx), .o_cpu_rst(o_cpu_rst), .o_wen(o_wen),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_wen === 1'b1) wq.push_back({o_waddr, o_wdata});

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    i_rx = 1'b0; wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin i_rx = b[i]; wait_clks(CPB); end
    i_rx = stop_bit; wait_clks(CPB);
    i_rx = 1'b1; wait_clks(CPB);
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(8'hA5, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    tb_csum = n[7:0] ^ n[15:8];
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b1);
      tb_csum = tb_csum ^ w[8*i +: 8];
    end
  endtask

  task automatic send_csum();
`ifdef BOOT_CHECKSUM_EN
    send_byte(tb_csum, 1'b1);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; i_rx = 1'b1; wait_clks(3);
    total++; if (o_cpu_rst !== 1'b1) begin bad++; $display("FAIL rst_cpu_rst got=%b exp=1", o_cpu_rst); end
    total++; if (o_wen !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b exp=0", o_wen); end
    total++; if (o_waddr !== 12'd0) begin bad++; $display("FAIL rst_waddr got=%h exp=0", o_waddr); end
    total++; if (o_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", o_wdata); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", o_error); end
    rst = 1'b0; wait_clks(CPB * 2);
  endtask

  task automatic test_load();
    wq.delete();
    send_header(16'd2);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b exp=1", o_busy); end
    total++; if (o_cpu_rst !== 1'b1) begin bad++; $display("FAIL load_cpu_rst_hold got=%b exp=1", o_cpu_rst); end
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    total++; if (wq.size() !== 2) begin bad++; $display("FAIL load_wcount got=%0d exp=2", wq.size()); end
    got_w = (wq.size() > 0) ? wq[0] : 44'h0;
    total++; if (got_w !== {12'd0, 32'h12345678}) begin bad++; $display("FAIL load_w0 got=%h exp=%h", got_w, {12'd0, 32'h12345678}); end
    got_w = (wq.size() > 1) ? wq[1] : 44'h0;
    total++; if (got_w !== {12'd1, 32'hDEADBEEF}) begin bad++; $display("FAIL load_w1 got=%h exp=%h", got_w, {12'd1, 32'hDEADBEEF}); end
    send_csum();
    wait_clks(4);
    total++; if (o_cpu_rst !== 1'b0) begin bad++; $display("FAIL load_run got=%b exp=0", o_cpu_rst); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL load_idle_busy got=%b exp=0", o_busy); end
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL load_error got=%b exp=0", o_error); end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_csum_bad();
    wq.delete();
    send_header(16'd2);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    send_byte(8'h00, 1'b1);
    wait_clks(4);
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL csum_error got=%b exp=1", o_error); end
    total++; if (o_cpu_rst !== 1'b1) begin bad++; $display("FAIL csum_cpu_rst got=%b exp=1", o_cpu_rst); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL csum_busy got=%b exp=0", o_busy); end
    total++; if (wq.size() !== 2) begin bad++; $display("FAIL csum_wcount got=%0d exp=2", wq.size()); end
  endtask
`endif

  task automatic test_len_overflow();
    wq.delete();
    send_header(16'h1001);
    wait_clks(4);
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL ovf_error got=%b exp=1", o_error); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL ovf_busy got=%b exp=0", o_busy); end
    total++; if (o_cpu_rst !== 1'b1) begin bad++; $display("FAIL ovf_cpu_rst got=%b exp=1", o_cpu_rst); end
    total++; if (wq.size() !== 0) begin bad++; $display("FAIL ovf_wcount got=%0d exp=0", wq.size()); end
  endtask

  task automatic test_len_max();
    send_header(16'h1000);
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL max_error got=%b exp=0", o_error); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL max_busy got=%b exp=1", o_busy); end
    send_byte(8'h33, 1'b0);
    wait_clks(4);
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL max_abort_error got=%b exp=1", o_error); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL max_abort_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_framing();
    wq.delete();
    send_header(16'd2);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b0);
    wait_clks(4);
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL frm_error got=%b exp=1", o_error); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL frm_busy got=%b exp=0", o_busy); end
    total++; if (o_cpu_rst !== 1'b1) begin bad++; $display("FAIL frm_cpu_rst got=%b exp=1", o_cpu_rst); end
    send_byte(8'hA5, 1'b1);
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL frm_clear got=%b exp=0", o_error); end
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    tb_csum = 8'h01;
    send_word(32'h44332211);
    send_csum();
    wait_clks(4);
    total++; if (wq.size() !== 1) begin bad++; $display("FAIL frm_wcount got=%0d exp=1", wq.size()); end
    got_w = (wq.size() > 0) ? wq[0] : 44'h0;
    total++; if (got_w !== {12'd0, 32'h44332211}) begin bad++; $display("FAIL frm_w0 got=%h exp=%h", got_w, {12'd0, 32'h44332211}); end
    total++; if (o_cpu_rst !== 1'b0) begin bad++; $display("FAIL frm_run got=%b exp=0", o_cpu_rst); end
  endtask

  task automatic test_zero_len();
    wq.delete();
    send_header(16'd0);
    send_csum();
    wait_clks(4);
    total++; if (o_cpu_rst !== 1'b0) begin bad++; $display("FAIL zero_run got=%b exp=0", o_cpu_rst); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", o_busy); end
    total++; if (wq.size() !== 0) begin bad++; $display("FAIL zero_wcount got=%0d exp=0", wq.size()); end
  endtask

  task automatic test_reload();
    wq.delete();
    send_byte(8'hA5, 1'b1);
    total++; if (o_cpu_rst !== 1'b1) begin bad++; $display("FAIL reload_cpu_rst got=%b exp=1", o_cpu_rst); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL reload_busy got=%b exp=1", o_busy); end
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    tb_csum = 8'h01;
    send_word(32'hDDCCBBAA);
    send_csum();
    wait_clks(4);
    got_w = (wq.size() > 0) ? wq[0] : 44'h0;
    total++; if (got_w !== {12'd0, 32'hDDCCBBAA}) begin bad++; $display("FAIL reload_w0 got=%h exp=%h", got_w, {12'd0, 32'hDDCCBBAA}); end
    total++; if (o_cpu_rst !== 1'b0) begin bad++; $display("FAIL reload_run got=%b exp=0", o_cpu_rst); end
  endtask

  task automatic test_rst_glitch();
    wq.delete();
    send_header(16'd1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    i_rx = 1'b0; wait_clks(CPB * 3);
    rst = 1'b1; wait_clks(1);
    i_rx = 1'b1;
    total++; if (o_cpu_rst !== 1'b1) begin bad++; $display("FAIL mid_cpu_rst got=%b exp=1", o_cpu_rst); end
    total++; if (o_wdata !== 32'd0) begin bad++; $display("FAIL mid_wdata got=%h exp=0", o_wdata); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", o_busy); end
    total++; if (o_wen !== 1'b0) begin bad++; $display("FAIL mid_wen got=%b exp=0", o_wen); end
    rst = 1'b0; wait_clks(CPB * 2);
    send_byte(8'hA5, 1'b1);
    i_rx = 1'b0; wait_clks(CPB / 4);
    i_rx = 1'b1; wait_clks(CPB * 2);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%b exp=1", o_busy); end
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    tb_csum = 8'h01;
    send_word(32'h0BADF00D);
    send_csum();
    wait_clks(4);
    total++; if (wq.size() !== 1) begin bad++; $display("FAIL glitch_wcount got=%0d exp=1", wq.size()); end
    got_w = (wq.size() > 0) ? wq[0] : 44'h0;
    total++; if (got_w !== {12'd0, 32'h0BADF00D}) begin bad++; $display("FAIL glitch_w0 got=%h exp=%h", got_w, {12'd0, 32'h0BADF00D}); end
    total++; if (o_cpu_rst !== 1'b0) begin bad++; $display("FAIL glitch_run got=%b exp=0", o_cpu_rst); end
  endtask

  initial begin
    test_reset();
    test_load();
`ifdef BOOT_CHECKSUM_EN
    test_csum_bad();
`endif
    test_len_overflow();
    test_len_max();
    test_framing();
    test_zero_len();
    test_reload();
    test_rst_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
